// File: rtl/register_dump_reader_pkg.sv
// Shared definitions for the debug register dump reader: defaults and FSM state encoding.
package register_dump_reader_pkg;

  localparam int         BYTES_PER_WORD             = 4;
  localparam int         DEFAULT_DATA_WIDTH         = BYTES_PER_WORD * 8;
  localparam int         DEFAULT_REGISTER_ADDR_BITS = 5;
  localparam logic [7:0] DEFAULT_FRAME_HEADER       = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_CAPTURE,
    S_SEND_ADDR,
    S_SEND_DATA,
    S_FINISH
  } state_t;

endpackage

// File: rtl/register_dump_reader_if.sv
// Byte stream valid/ready link from the dump reader to the UART transmitter.
interface register_dump_reader_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/register_dump_reader.sv
// Walks the register bank debug port and streams header, address and MSB-first data bytes
// for every register over a valid/ready byte link.
module register_dump_reader
  import register_dump_reader_pkg::*;
#(
  parameter int         DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int         REGISTER_ADDR_BITS = DEFAULT_REGISTER_ADDR_BITS,
  parameter logic [7:0] FRAME_HEADER       = DEFAULT_FRAME_HEADER
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dump_start,
  output logic [REGISTER_ADDR_BITS-1:0] register_data_debug_address,
  input  logic [DATA_WIDTH-1:0]         register_data_debug,
  register_dump_reader_if.master        byte_stream,
  output logic                          busy,
  output logic                          done
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0]              LAST_BYTE = CNT_W'(WORD_BYTES - 1);
  localparam logic [REGISTER_ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                        state;
  logic [REGISTER_ADDR_BITS-1:0] addr_cnt;
  logic [CNT_W-1:0]              byte_cnt;
  logic [DATA_WIDTH-1:0]         shift_reg;
  logic                          transfer;

  assign transfer = byte_stream.byte_valid && byte_stream.byte_ready;

  // The bank port is combinational, so the registered counter gives a stable address.
  assign register_data_debug_address = addr_cnt;

  // NOTE: every register here is assigned with <= so all branches see the pre-edge values;
  // a blocking assignment would let later statements observe a half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= S_IDLE;
      addr_cnt               <= '0;
      byte_cnt               <= '0;
      shift_reg              <= '0;
      byte_stream.byte_data  <= '0;
      byte_stream.byte_valid <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dump_start) begin
            state    <= S_HEADER;
            addr_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        S_HEADER: begin
          if (!byte_stream.byte_valid) begin
            byte_stream.byte_data  <= FRAME_HEADER;
            byte_stream.byte_valid <= 1'b1;
          end else if (transfer) begin
            byte_stream.byte_valid <= 1'b0;
            state                  <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // Snapshot the word and present its address byte in the same edge.
          shift_reg              <= register_data_debug;
          byte_stream.byte_data  <= 8'(addr_cnt);
          byte_stream.byte_valid <= 1'b1;
          state                  <= S_SEND_ADDR;
        end

        S_SEND_ADDR: begin
          if (transfer) begin
            byte_stream.byte_data <= shift_reg[DATA_WIDTH-1 -: 8];
            shift_reg             <= shift_reg << 8;
            byte_cnt              <= '0;
            state                 <= S_SEND_DATA;
          end
        end

        S_SEND_DATA: begin
          if (transfer) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_stream.byte_valid <= 1'b0;
              if (addr_cnt == LAST_ADDR) begin
                state <= S_FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                addr_cnt <= addr_cnt + 1'b1;
                state    <= S_CAPTURE;
              end
            end else begin
              byte_stream.byte_data <= shift_reg[DATA_WIDTH-1 -: 8];
              shift_reg             <= shift_reg << 8;
              byte_cnt              <= byte_cnt + 1'b1;
            end
          end
        end

        S_FINISH: begin
          addr_cnt <= '0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed bench for register_dump_reader: frame content, backpressure, live writes,
// ignored restarts and mid-frame reset against a small bank model.
module tb_register_dump_reader;
  import register_dump_reader_pkg::*;

  localparam int N         = 32;
  localparam int FRAME_LEN = 161;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dump_start = 1'b0;
  logic [4:0]  addr;
  logic [31:0] rdata;
  logic        busy;
  logic        done;

  register_dump_reader_if bs();

  logic [31:0] bank     [N];
  logic [31:0] exp_regs [N];
  assign rdata = bank[addr];

  always #5 clk = ~clk;

  register_dump_reader dut (
    .clk                         (clk),
    .reset                       (reset),
    .dump_start                  (dump_start),
    .register_data_debug_address (addr),
    .register_data_debug         (rdata),
    .byte_stream                 (bs),
    .busy                        (busy),
    .done                        (done)
  );

  int         errors = 0;
  int         checks = 0;
  int         done_count = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         rand_ready = 1'b0;
  logic [7:0] rx    [$];
  logic [7:0] exp_q [$];

  // Collects transfers and checks hold-while-stalled, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (bs.byte_valid && bs.byte_ready) rx.push_back(bs.byte_data);
      if (prev_stall && (!bs.byte_valid || bs.byte_data != prev_data)) stall_err <= stall_err + 1;
      if (done) done_count <= done_count + 1;
      prev_stall <= bs.byte_valid && !bs.byte_ready;
      prev_data  <= bs.byte_data;
    end
  end

  initial begin
    bs.byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bs.byte_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int k;
    start = done_count;
    k = 0;
    while (done_count == start && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_count != start), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_bytes_reached"}, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic load_bank();
    for (int i = 0; i < N; i++) begin
      bank[i]     = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      exp_regs[i] = bank[i];
    end
  endtask

  task automatic build_expected();
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++) begin
      w = exp_regs[i];
      exp_q.push_back(8'(i));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic compare_frame(input string tag);
    int mism;
    int lim;
    build_expected();
    mism = 0;
    lim  = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    check({tag, "_frame_len"}, 32'(rx.size()), 32'(FRAME_LEN));
    for (int i = 0; i < lim; i++)
      if (rx[i] !== exp_q[i]) mism++;
    check({tag, "_frame_bytes_wrong"}, 32'(mism), 32'd0);
  endtask

  task automatic rx_byte(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    v = (idx < rx.size()) ? rx[idx] : 8'hxx;
    check(tag, {24'h0, v}, {24'h0, exp});
  endtask

  logic [7:0] head_vec [11];
  logic [7:0] tail_vec [5];
  int base;
  bit seen;

  initial begin
    head_vec = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h01};
    tail_vec = '{8'h1F, 8'h10, 8'h00, 8'h00, 8'h1F};
    load_bank();

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(bs.byte_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_addr",  32'(addr), 32'd0);
    check("rst_data",  32'(bs.byte_data), 32'd0);
    reset = 1'b1;
    tick();

    // Full frame with ready high, plus first-byte latency
    rx.delete();
    base = done_count;
    start_dump();
    check("lat_busy_t1",  32'(busy), 32'd1);
    check("lat_valid_t1", 32'(bs.byte_valid), 32'd0);
    tick();
    check("lat_valid_t2", 32'(bs.byte_valid), 32'd1);
    check("lat_data_t2",  32'(bs.byte_data), 32'hA5);
    wait_done("f1", 1000);
    check("f1_done_one_cycle", 32'(done), 32'd0);
    check("f1_busy_after", 32'(busy), 32'd0);
    check("f1_addr_idle", 32'(addr), 32'd0);
    repeat (5) tick();
    check("f1_done_pulses", 32'(done_count - base), 32'd1);
    compare_frame("f1");
    for (int i = 0; i < 11; i++) rx_byte("f1_head_byte", i, head_vec[i]);
    for (int i = 0; i < 5; i++)  rx_byte("f1_tail_byte", FRAME_LEN - 5 + i, tail_vec[i]);

    // Backpressure: ready high ~30% of cycles
    rx.delete();
    base = stall_err;
    rand_ready = 1'b1;
    start_dump();
    wait_done("bp", 5000);
    rand_ready = 1'b0;
    repeat (3) tick();
    compare_frame("bp");
    check("bp_hold_violations", 32'(stall_err - base), 32'd0);

    // Live writes while address 2 is being dumped
    rx.delete();
    start_dump();
    begin
      int k;
      k = 0;
      while (addr != 5'd2 && k < 1000) begin
        tick();
        k++;
      end
      check("live_addr2_reached", 32'(addr), 32'd2);
    end
    bank[5]     = 32'hDEAD_BEEF;
    bank[1]     = 32'hCAFE_0001;
    exp_regs[5] = 32'hDEAD_BEEF;
    wait_done("live", 1000);
    repeat (3) tick();
    compare_frame("live");
    rx_byte("live_r5_b0", 27, 8'hDE);
    rx_byte("live_r5_b3", 30, 8'hEF);
    rx_byte("live_r1_b0", 7, 8'h10);
    rx_byte("live_r1_b3", 10, 8'h01);
    load_bank();

    // dump_start while busy and in the FINISH cycle is ignored
    rx.delete();
    base = done_count;
    start_dump();
    wait_bytes("dbl", 40, 1000);
    start_dump();
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        start_dump();
      end else begin
        tick();
      end
    end
    check("dbl_finish_seen", 32'(seen), 32'd1);
    repeat (20) tick();
    check("dbl_done_pulses", 32'(done_count - base), 32'd1);
    check("dbl_busy_after", 32'(busy), 32'd0);
    check("dbl_valid_after", 32'(bs.byte_valid), 32'd0);
    compare_frame("dbl");

    // Reset mid-frame, then a fresh frame
    rx.delete();
    start_dump();
    wait_bytes("mr", 80, 1000);
    reset = 1'b0;
    #1;
    check("mr_valid_in_reset", 32'(bs.byte_valid), 32'd0);
    check("mr_busy_in_reset", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    rx.delete();
    start_dump();
    wait_done("mr", 1000);
    repeat (3) tick();
    compare_frame("mr");
    rx_byte("mr_first_byte", 0, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
